// File: rtl/switch_conditioner.sv
// switch_conditioner: two-flop synchronizer plus per-channel debounce FSM for
// raw switch/pushbutton levels. Emits clean levels and one-cycle rise/fall
// pulses on each accepted change.
module switch_conditioner #(
  parameter int WIDTH           = 3,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  typedef enum logic {ST_STABLE, ST_CHECK} state_t;

  // Last count value before a persisting level is accepted.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;

  // Two-flop synchronizer: only sync2_q is used by the debounce logic.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sw_in;
      sync2_q <= sync1_q;
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_chan
    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             out_q, out_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             accept;

    // Next-state logic: a differing level must persist DEBOUNCE_CYCLES
    // synchronized cycles; any return to the current level restarts timing.
    always_comb begin
      state_d = state_q;
      count_d = count_q;
      out_d   = out_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      accept  = 1'b0;
      unique case (state_q)
        ST_STABLE: begin
          if (sync2_q[g] != out_q) begin
            if (DEBOUNCE_CYCLES == 1) begin
              accept = 1'b1;
            end else begin
              state_d = ST_CHECK;
              count_d = CNT_W'(1);
            end
          end
        end
        ST_CHECK: begin
          if (sync2_q[g] == out_q) begin
            state_d = ST_STABLE;
            count_d = '0;
          end else if (count_q == CNT_LAST) begin
            accept = 1'b1;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_STABLE;
          count_d = '0;
        end
      endcase
      if (accept) begin
        out_d   = sync2_q[g];
        count_d = '0;
        state_d = ST_STABLE;
        rise_d  = sync2_q[g];
        fall_d  = ~sync2_q[g];
      end
    end

    // Channel state register; pulses fall back to 0 on every non-accept edge.
    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= ST_STABLE;
        count_q <= '0;
        out_q   <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        count_q <= count_d;
        out_q   <= out_d;
        rise_q  <= rise_d;
        fall_q  <= fall_d;
      end
    end

    assign sw_out[g] = out_q;
    assign rise[g]   = rise_q;
    assign fall[g]   = fall_q;
  end

  assign changed = |{rise, fall};

endmodule
